// File: rtl/mux_seq.sv
// Registered channel multiplexer with a valid/ready output stage.
// Channels are picked either by an explicit select or by a round-robin scan over a channel mask.
module mux_seq #(
    parameter int N  = 16,
    parameter int W  = 8,
    parameter int SW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in,
    input  logic            en,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [N-1:0]    ch_mask,
    output logic [W-1:0]    y,
    output logic [SW-1:0]   y_ch,
    output logic            y_err,
    output logic            y_valid,
    input  logic            y_ready
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    y_q, y_d;
    logic [SW-1:0]   y_ch_q, y_ch_d;
    logic            y_err_q, y_err_d;
    logic [SW-1:0]   ptr_q, ptr_d;

    logic            cap_opp_s;
    logic            man_in_range_s;
    logic [W-1:0]    man_data_s;
    logic            auto_found_s;
    logic [2*N-1:0]  mask_dbl_s;
    logic [N-1:0]    mask_rot_s;
    logic [SW-1:0]   auto_off_s;
    logic [SW:0]     auto_sum_s;
    logic [SW-1:0]   auto_ch_s;
    logic [W-1:0]    auto_data_s;
    logic [SW-1:0]   ptr_next_s;

    // An index that matches no channel yields all zeros, which is the out-of-range data value.
    function automatic logic [W-1:0] pick_ch(input logic [N*W-1:0] bus, input logic [SW-1:0] idx);
        logic [W-1:0] acc;
        acc = '0;
        for (int c = 0; c < N; c++) begin
            acc = acc | ((idx == SW'(c)) ? bus[c*W +: W] : {W{1'b0}});
        end
        return acc;
    endfunction

    // Select index compared against every legal channel number.
    function automatic logic idx_in_range(input logic [SW-1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < N; c++) begin
            hit = hit | (idx == SW'(c));
        end
        return hit;
    endfunction

    // Manual-select path.
    always_comb begin
        man_in_range_s = idx_in_range(sel);
        man_data_s     = pick_ch(in, sel);
    end

    // Round-robin search: rotate the mask so bit 0 is the channel at ptr, then take the lowest set bit.
    always_comb begin
        auto_found_s = |ch_mask;
        mask_dbl_s   = {ch_mask, ch_mask} >> ptr_q;
        mask_rot_s   = mask_dbl_s[N-1:0];
        auto_off_s   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            auto_off_s = mask_rot_s[i] ? SW'(i) : auto_off_s;
        end
        auto_sum_s = {1'b0, ptr_q} + {1'b0, auto_off_s};
        if (auto_sum_s >= (SW+1)'(N)) begin
            auto_sum_s = auto_sum_s - (SW+1)'(N);
        end else begin
            auto_sum_s = auto_sum_s;
        end
        auto_ch_s   = auto_sum_s[SW-1:0];
        auto_data_s = pick_ch(in, auto_ch_s);
        if (auto_ch_s == SW'(N - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = auto_ch_s + SW'(1);
        end
    end

    // Capture opportunity: always in IDLE, in HOLD only when the held sample is accepted.
    always_comb begin
        case (state_q)
            ST_IDLE: cap_opp_s = 1'b1;
            ST_HOLD: cap_opp_s = y_ready;
            default: cap_opp_s = 1'b1;
        endcase
    end

    // Next-state and output-register update.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        y_ch_d  = y_ch_q;
        y_err_d = y_err_q;
        ptr_d   = ptr_q;
        if (cap_opp_s) begin
            if (en && (!mode || auto_found_s)) begin
                state_d = ST_HOLD;
                if (mode) begin
                    y_d     = auto_data_s;
                    y_ch_d  = auto_ch_s;
                    y_err_d = 1'b0;
                    ptr_d   = ptr_next_s;
                end else begin
                    y_d     = man_data_s;
                    y_ch_d  = sel;
                    y_err_d = !man_in_range_s;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            y_ch_q  <= '0;
            y_err_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            y_ch_q  <= y_ch_d;
            y_err_q <= y_err_d;
            ptr_q   <= ptr_d;
        end
    end

    assign y       = y_q;
    assign y_ch    = y_ch_q;
    assign y_err   = y_err_q;
    assign y_valid = (state_q == ST_HOLD);

endmodule

// File: tb/tb_mux_seq.sv
// Directed bench for mux_seq: default 16-channel instance plus a 12-channel instance for out-of-range selects.
module tb_mux_seq;

    logic          clk;
    logic          rst;

    logic [127:0]  in_s;
    logic          en_s, mode_s, y_ready_s;
    logic [3:0]    sel_s;
    logic [15:0]   ch_mask_s;
    logic [7:0]    y_s;
    logic [3:0]    y_ch_s;
    logic          y_err_s, y_valid_s;

    logic [95:0]   in12_s;
    logic          en12_s, mode12_s, y_ready12_s;
    logic [3:0]    sel12_s;
    logic [11:0]   ch_mask12_s;
    logic [7:0]    y12_s;
    logic [3:0]    y_ch12_s;
    logic          y_err12_s, y_valid12_s;

    int checks;
    int errors;
    logic [13:0] obs;
    logic [13:0] exp_v;

    mux_seq dut (
        .clk(clk), .rst(rst), .in(in_s), .en(en_s), .mode(mode_s), .sel(sel_s),
        .ch_mask(ch_mask_s), .y(y_s), .y_ch(y_ch_s), .y_err(y_err_s),
        .y_valid(y_valid_s), .y_ready(y_ready_s)
    );

    mux_seq #(.N(12), .W(8), .SW(4)) dut12 (
        .clk(clk), .rst(rst), .in(in12_s), .en(en12_s), .mode(mode12_s), .sel(sel12_s),
        .ch_mask(ch_mask12_s), .y(y12_s), .y_ch(y_ch12_s), .y_err(y_err12_s),
        .y_valid(y_valid12_s), .y_ready(y_ready12_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare the 16-channel outputs packed as {valid, err, ch, y}.
    task automatic chk(input string name, input logic [13:0] e);
        obs = {y_valid_s, y_err_s, y_ch_s, y_s};
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL %s: got v=%b e=%b ch=%0d y=%h, expected v=%b e=%b ch=%0d y=%h",
                     name, obs[13], obs[12], obs[11:8], obs[7:0], e[13], e[12], e[11:8], e[7:0]);
        end
    endtask

    task automatic fill_in(input logic [7:0] base);
        for (int c = 0; c < 16; c++) in_s[c*8 +: 8] = base + 8'(c);
    endtask

    task automatic test_reset();
        rst = 1'b1; en_s = 1'b1; y_ready_s = 1'b1; mode_s = 1'b0; sel_s = 4'd5;
        en12_s = 1'b1; y_ready12_s = 1'b1;
        tick();
        chk("reset_state", {1'b0, 1'b0, 4'd0, 8'h00});
        checks++;
        if (y_valid12_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid12: got %b expected 0", y_valid12_s);
        end
        rst = 1'b0; en_s = 1'b0; en12_s = 1'b0;
        tick();
        chk("idle_after_reset", {1'b0, 1'b0, 4'd0, 8'h00});
    endtask

    task automatic test_manual();
        fill_in(8'h30);
        in_s[5*8 +: 8] = 8'hA5;
        mode_s = 1'b0; sel_s = 4'd5; en_s = 1'b1; y_ready_s = 1'b1;
        tick();
        chk("manual_ch5", {1'b1, 1'b0, 4'd5, 8'hA5});
        sel_s = 4'd0;
        tick();
        chk("manual_ch0", {1'b1, 1'b0, 4'd0, 8'h30});
        sel_s = 4'd15;
        tick();
        chk("manual_ch15", {1'b1, 1'b0, 4'd15, 8'h3F});
        en_s = 1'b0;
        tick();
        chk("manual_en_low", {1'b0, 1'b0, 4'd15, 8'h3F});
        tick();
        chk("manual_idle_stays", {1'b0, 1'b0, 4'd15, 8'h3F});
    endtask

    task automatic test_out_of_range();
        for (int c = 0; c < 12; c++) in12_s[c*8 +: 8] = 8'h50 + 8'(c);
        mode12_s = 1'b0; sel12_s = 4'd13; en12_s = 1'b1; y_ready12_s = 1'b1; ch_mask12_s = 12'hFFF;
        tick();
        exp_v = {1'b1, 1'b1, 4'd13, 8'h00};
        checks++;
        if ({y_valid12_s, y_err12_s, y_ch12_s, y12_s} !== exp_v) begin
            errors++;
            $display("FAIL oor_sel13: got %h expected %h", {y_valid12_s, y_err12_s, y_ch12_s, y12_s}, exp_v);
        end
        sel12_s = 4'd11;
        tick();
        exp_v = {1'b1, 1'b0, 4'd11, 8'h5B};
        checks++;
        if ({y_valid12_s, y_err12_s, y_ch12_s, y12_s} !== exp_v) begin
            errors++;
            $display("FAIL oor_sel11: got %h expected %h", {y_valid12_s, y_err12_s, y_ch12_s, y12_s}, exp_v);
        end
        sel12_s = 4'd12;
        tick();
        exp_v = {1'b1, 1'b1, 4'd12, 8'h00};
        checks++;
        if ({y_valid12_s, y_err12_s, y_ch12_s, y12_s} !== exp_v) begin
            errors++;
            $display("FAIL oor_sel12: got %h expected %h", {y_valid12_s, y_err12_s, y_ch12_s, y12_s}, exp_v);
        end
        en12_s = 1'b0;
        tick();
        exp_v = {1'b0, 1'b1, 4'd12, 8'h00};
        checks++;
        if ({y_valid12_s, y_err12_s, y_ch12_s, y12_s} !== exp_v) begin
            errors++;
            $display("FAIL oor_idle: got %h expected %h", {y_valid12_s, y_err12_s, y_ch12_s, y12_s}, exp_v);
        end
    endtask

    task automatic test_auto_wrap();
        mode_s = 1'b1; ch_mask_s = 16'h8011; en_s = 1'b1; y_ready_s = 1'b1;
        tick();
        chk("auto_ch0", {1'b1, 1'b0, 4'd0, 8'h30});
        tick();
        chk("auto_ch4", {1'b1, 1'b0, 4'd4, 8'h34});
        tick();
        chk("auto_ch15", {1'b1, 1'b0, 4'd15, 8'h3F});
        tick();
        chk("auto_wrap_ch0", {1'b1, 1'b0, 4'd0, 8'h30});
        mode_s = 1'b0; sel_s = 4'd7;
        tick();
        chk("manual_between_auto", {1'b1, 1'b0, 4'd7, 8'h37});
        mode_s = 1'b1;
        tick();
        chk("auto_ptr_kept", {1'b1, 1'b0, 4'd4, 8'h34});
        en_s = 1'b0;
        tick();
        chk("auto_idle", {1'b0, 1'b0, 4'd4, 8'h34});
    endtask

    task automatic test_backpressure();
        en_s = 1'b1; y_ready_s = 1'b0;
        tick();
        chk("bp_capture", {1'b1, 1'b0, 4'd15, 8'h3F});
        fill_in(8'h60); ch_mask_s = 16'h0002; sel_s = 4'd3;
        tick();
        chk("bp_hold1", {1'b1, 1'b0, 4'd15, 8'h3F});
        en_s = 1'b0; mode_s = 1'b0;
        tick();
        chk("bp_hold2", {1'b1, 1'b0, 4'd15, 8'h3F});
        en_s = 1'b1; mode_s = 1'b1;
        tick();
        chk("bp_hold3", {1'b1, 1'b0, 4'd15, 8'h3F});
        y_ready_s = 1'b1;
        tick();
        chk("bp_release", {1'b1, 1'b0, 4'd1, 8'h61});
        en_s = 1'b0;
        tick();
        chk("bp_idle", {1'b0, 1'b0, 4'd1, 8'h61});
    endtask

    task automatic test_mask_zero();
        ch_mask_s = 16'h0000; en_s = 1'b1; y_ready_s = 1'b1;
        tick();
        chk("mask0_a", {1'b0, 1'b0, 4'd1, 8'h61});
        tick();
        chk("mask0_b", {1'b0, 1'b0, 4'd1, 8'h61});
        ch_mask_s = 16'h0004;
        tick();
        chk("mask_ch2", {1'b1, 1'b0, 4'd2, 8'h62});
    endtask

    task automatic test_reset_hold();
        rst = 1'b1;
        tick();
        chk("reset_in_hold", {1'b0, 1'b0, 4'd0, 8'h00});
        rst = 1'b0; ch_mask_s = 16'hFFFF;
        tick();
        chk("post_reset_ch0", {1'b1, 1'b0, 4'd0, 8'h60});
        tick();
        chk("post_reset_ch1", {1'b1, 1'b0, 4'd1, 8'h61});
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        in_s = '0; en_s = 1'b0; mode_s = 1'b0; sel_s = 4'd0; ch_mask_s = 16'h0000; y_ready_s = 1'b0;
        in12_s = '0; en12_s = 1'b0; mode12_s = 1'b0; sel12_s = 4'd0; ch_mask12_s = 12'h000; y_ready12_s = 1'b0;
        test_reset();
        test_manual();
        test_out_of_range();
        test_auto_wrap();
        test_backpressure();
        test_mask_zero();
        test_reset_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
